// File: rtl/dplca_txop_table_if.sv
`default_nettype none
// ============================================================================
//  Module   : dplca_txop_table_if
//  Purpose  : Signal bundle between the PLCA control state diagram and the
//             DPLCA TXOP table manager.
//  Signals  : dplca_en             - DPLCA enable (0 holds the table cleared)
//             dplca_aging          - 1 = unclaimed TXOPs age
//             dplca_txop_claim     - 2'b01 = CLAIMED, other codes UNCLAIMED
//             dplca_txop_end       - high while control FSM in NEXT_TX_OPPORTUNITY
//             dplca_txop_id        - ID of the TXOP that just ended
//             dplca_txop_table_upd - table update complete handshake
//             dplca_node_count     - derived PLCA node count
//             table_state          - manager FSM state
//             busy                 - manager not idle
//  Modports : master = control side (drives the requests)
//             slave  = table manager
//  Revision : 1.0 - initial release
// ============================================================================
interface dplca_txop_table_if;
  logic       dplca_en;
  logic       dplca_aging;
  logic [1:0] dplca_txop_claim;
  logic       dplca_txop_end;
  logic [7:0] dplca_txop_id;
  logic       dplca_txop_table_upd;
  logic [7:0] dplca_node_count;
  logic [1:0] table_state;
  logic       busy;

  modport master (
    output dplca_en, dplca_aging, dplca_txop_claim, dplca_txop_end, dplca_txop_id,
    input  dplca_txop_table_upd, dplca_node_count, table_state, busy
  );

  modport slave (
    input  dplca_en, dplca_aging, dplca_txop_claim, dplca_txop_end, dplca_txop_id,
    output dplca_txop_table_upd, dplca_node_count, table_state, busy
  );
endinterface
`default_nettype wire

// File: rtl/dplca_txop_table.sv
`default_nettype none
// ============================================================================
//  Module   : dplca_txop_table
//  Purpose  : Dynamic PLCA TXOP table manager. Ages a per-TXOP counter on
//             every transmit opportunity end, scans the table for the highest
//             live TXOP, derives the node count and hands a table-updated
//             strobe back to the PLCA control FSM.
//  Ports    : clk   - block clock
//             reset - synchronous, active-high reset
//             bus   - dplca_txop_table_if slave modport (see interface file)
//  Revision : 1.0 - initial release
// ============================================================================
module dplca_txop_table #(
  parameter int TABLE_SIZE = 16,
  parameter int AGE_MAX    = 3,
  parameter int MIN_NC     = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  dplca_txop_table_if.slave    bus
);

  localparam int             IDX_W        = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
  localparam logic [8:0]     c_TABLE_SIZE = 9'(TABLE_SIZE);
  localparam logic [7:0]     c_AGE_MAX    = 8'(AGE_MAX);
  localparam logic [7:0]     c_MIN_NC     = 8'(MIN_NC);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(TABLE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_UPDATE = 2'b01,
    S_SCAN   = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_age [TABLE_SIZE];

  // Input sample stage: the start is the rising edge of the *registered*
  // txop_end, so id/claim are registered alongside it to stay aligned.
  logic             r_end_q;
  logic             r_end_qq;
  logic [7:0]       r_id_q;
  logic             r_claimed_q;

  logic [7:0]       r_cur_id;
  logic             r_cur_claimed;
  logic             r_pend;
  logic [7:0]       r_pend_id;
  logic             r_pend_claimed;

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_hi;
  logic             r_upd;
  logic [7:0]       r_nc;

  logic             w_clear;
  logic             w_start;
  logic             w_done_exit;
  logic [7:0]       w_age_sel;
  logic [7:0]       w_hi_nxt;
  logic [8:0]       w_nc_sum;
  logic [7:0]       w_nc_sat;
  logic [7:0]       w_nc;

  assign w_clear     = reset | ~bus.dplca_en;
  assign w_start     = r_end_q & ~r_end_qq;
  assign w_done_exit = (r_state == S_DONE) && !bus.dplca_txop_end;

  // Entry 0 is the coordinator and is always treated as live.
  assign w_age_sel = r_age[r_idx];
  assign w_hi_nxt  = ((r_idx == '0) || (w_age_sel != 8'd0)) ? 8'(r_idx) : r_hi;
  assign w_nc_sum  = {1'b0, w_hi_nxt} + 9'd2;
  assign w_nc_sat  = w_nc_sum[8] ? 8'hFF : w_nc_sum[7:0];
  assign w_nc      = (w_nc_sat < c_MIN_NC) ? c_MIN_NC : w_nc_sat;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_SCAN;
      S_SCAN:   if (r_idx == c_LAST_IDX) w_state_nxt = S_DONE;
      S_DONE:   if (w_done_exit) w_state_nxt = (r_pend || w_start) ? S_UPDATE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < TABLE_SIZE; i++) r_age[i] <= 8'd0;
      r_end_q        <= 1'b0;
      r_end_qq       <= 1'b0;
      r_id_q         <= 8'd0;
      r_claimed_q    <= 1'b0;
      r_cur_id       <= 8'd0;
      r_cur_claimed  <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_id      <= 8'd0;
      r_pend_claimed <= 1'b0;
      r_idx          <= '0;
      r_hi           <= 8'd0;
      r_upd          <= 1'b0;
      r_nc           <= c_MIN_NC;
    end else begin
      r_end_q     <= bus.dplca_txop_end;
      r_end_qq    <= r_end_q;
      r_id_q      <= bus.dplca_txop_id;
      r_claimed_q <= (bus.dplca_txop_claim == 2'b01);

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cur_id      <= r_id_q;
            r_cur_claimed <= r_claimed_q;
          end
        end
        S_UPDATE: begin
          // Out-of-range IDs leave the table untouched; ages saturate at 0.
          if ({1'b0, r_cur_id} < c_TABLE_SIZE) begin
            if (r_cur_claimed)
              r_age[r_cur_id[IDX_W-1:0]] <= c_AGE_MAX;
            else if (bus.dplca_aging && (r_age[r_cur_id[IDX_W-1:0]] != 8'd0))
              r_age[r_cur_id[IDX_W-1:0]] <= r_age[r_cur_id[IDX_W-1:0]] - 8'd1;
          end
          r_idx <= '0;
          r_hi  <= 8'd0;
        end
        S_SCAN: begin
          r_hi  <= w_hi_nxt;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == c_LAST_IDX) begin
            r_nc  <= w_nc;
            r_upd <= 1'b1;
          end
        end
        S_DONE: begin
          if (w_done_exit) begin
            r_upd  <= 1'b0;
            r_pend <= 1'b0;
            // A start seen on the exit cycle is newer than anything pending.
            if (w_start) begin
              r_cur_id      <= r_id_q;
              r_cur_claimed <= r_claimed_q;
            end else if (r_pend) begin
              r_cur_id      <= r_pend_id;
              r_cur_claimed <= r_pend_claimed;
            end
          end
        end
        default: ;
      endcase

      // One-deep pending slot, last start wins.
      if (w_start && (r_state != S_IDLE) && !w_done_exit) begin
        r_pend         <= 1'b1;
        r_pend_id      <= r_id_q;
        r_pend_claimed <= r_claimed_q;
      end
    end
  end

  assign bus.dplca_txop_table_upd = r_upd;
  assign bus.dplca_node_count     = r_nc;
  assign bus.table_state          = r_state;
  assign bus.busy                 = (r_state != S_IDLE);

endmodule
`default_nettype wire
